// File: rtl/gstmcu_vid_pkg.sv
// Shared vertical timing constants, mode type and frame-length helpers.
// Used by the vertical sync generator and its line counter.
package gstmcu_vid_pkg;

  localparam int VCNT_W = 9;

  localparam logic [VCNT_W-1:0] PAL_LINES  = 9'd313;
  localparam logic [VCNT_W-1:0] NTSC_LINES = 9'd263;
  localparam logic [VCNT_W-1:0] MONO_LINES = 9'd501;
  localparam logic [VCNT_W-1:0] VS_LEN     = 9'd3;
  localparam logic [VCNT_W-1:0] VB_PRE     = 9'd2;
  localparam logic [VCNT_W-1:0] VBE_PAL    = 9'd25;
  localparam logic [VCNT_W-1:0] VBE_NTSC   = 9'd16;
  localparam logic [VCNT_W-1:0] VBE_MONO   = 9'd34;

  typedef enum logic [1:0] {
    VM_PAL,
    VM_NTSC,
    VM_MONO
  } vmode_t;

  function automatic logic [VCNT_W-1:0] total_eff(
    input vmode_t m,
    input logic   il,
    input logic   fld
  );
    logic [VCNT_W-1:0] t;
    unique case (m)
      VM_NTSC: t = NTSC_LINES;
      VM_MONO: t = MONO_LINES;
      default: t = PAL_LINES;
    endcase
    // the short interlace field drops one line
    if (il && fld && (m != VM_MONO)) t = t - 9'd1;
    return t;
  endfunction

  function automatic logic [VCNT_W-1:0] vbe_line(
    input vmode_t m
  );
    logic [VCNT_W-1:0] v;
    unique case (m)
      VM_NTSC: v = VBE_NTSC;
      VM_MONO: v = VBE_MONO;
      default: v = VBE_PAL;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vsyncgen_vlinecnt.sv
// Line counter: advances on each enabled cycle, wraps at total-1.
// Also flags the wrap and emits a registered frame-start pulse.
module vlinecnt
  import gstmcu_vid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [VCNT_W-1:0] total,
  output logic [VCNT_W-1:0] cnt,
  output logic [VCNT_W-1:0] cnt_nxt,
  output logic              wrap,
  output logic              frame_stb
);

  // next count; >= also catches counts stranded past the end
  always_comb begin
    wrap    = en && (cnt >= (total - 9'd1));
    cnt_nxt = cnt;
    if (wrap)    cnt_nxt = '0;
    else if (en) cnt_nxt = cnt + 9'd1;
  end

  // count and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      frame_stb <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      frame_stb <= wrap;
    end
  end

endmodule

// File: rtl/vsyncgen.sv
// Vertical timing generator: line count, vsync, vblank, field, frame start.
// Mode inputs are sampled only when the line count wraps.
module vsyncgen
  import gstmcu_vid_pkg::*;
(
  input  logic              m2clock,
  input  logic              resb,
  input  logic              vertclk,
  input  logic              mde1,
  input  logic              ntsc,
  input  logic              interlace,
  output logic [VCNT_W-1:0] vcnt,
  output logic              vsync_n,
  output logic              vblank,
  output logic              field,
  output logic              frame_stb
);

  vmode_t            mode_q;
  vmode_t            mode_req;
  vmode_t            mode_nxt;
  logic              il_q;
  logic              il_nxt;
  logic              fld_nxt;
  logic              wrap;
  logic [VCNT_W-1:0] cnt_nxt;
  logic [VCNT_W-1:0] total_cur;
  logic [VCNT_W-1:0] total_nxt;
  logic              vs_d;
  logic              vb_d;

  vlinecnt u_cnt (
    .clk       (m2clock),
    .rst_n     (resb),
    .en        (!vertclk),
    .total     (total_cur),
    .cnt       (vcnt),
    .cnt_nxt   (cnt_nxt),
    .wrap      (wrap),
    .frame_stb (frame_stb)
  );

  // requested mode; mono overrides the ntsc select
  always_comb begin
    mode_req = VM_PAL;
    unique case (1'b1)
      mde1:          mode_req = VM_MONO;
      ntsc && !mde1: mode_req = VM_NTSC;
      default:       mode_req = VM_PAL;
    endcase
  end

  // mode/field for the next cycle, then decode from the next count
  always_comb begin
    mode_nxt = mode_q;
    il_nxt   = il_q;
    fld_nxt  = field;
    if (wrap) begin
      mode_nxt = mode_req;
      il_nxt   = interlace && !mde1;
      fld_nxt  = il_nxt ? !field : 1'b0;
    end
    total_cur = total_eff(mode_q, il_q, field);
    total_nxt = total_eff(mode_nxt, il_nxt, fld_nxt);
    vs_d = !(cnt_nxt >= (total_nxt - VS_LEN));
    vb_d = (cnt_nxt < vbe_line(mode_nxt))
        || (cnt_nxt >= (total_nxt - VS_LEN - VB_PRE));
  end

  // latched mode and registered decode outputs
  always_ff @(posedge m2clock or negedge resb) begin
    if (!resb) begin
      mode_q  <= VM_PAL;
      il_q    <= 1'b0;
      field   <= 1'b0;
      vsync_n <= 1'b1;
      vblank  <= 1'b1;
    end else begin
      mode_q  <= mode_nxt;
      il_q    <= il_nxt;
      field   <= fld_nxt;
      vsync_n <= vs_d;
      vblank  <= vb_d;
    end
  end

endmodule

// File: tb/tb_vsyncgen.sv
// Directed plus randomized bench for vsyncgen.
// Frame-level reference model checked on every clock.
module tb_vsyncgen;

  logic       m2clock = 1'b0;
  logic       resb;
  logic       vertclk;
  logic       mde1;
  logic       ntsc;
  logic       interlace;
  logic [8:0] vcnt;
  logic       vsync_n;
  logic       vblank;
  logic       field;
  logic       frame_stb;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: mode 0=PAL 1=NTSC 2=mono
  int mv, mmode, mil, mfld, mstb;

  vsyncgen dut (
    .m2clock   (m2clock),
    .resb      (resb),
    .vertclk   (vertclk),
    .mde1      (mde1),
    .ntsc      (ntsc),
    .interlace (interlace),
    .vcnt      (vcnt),
    .vsync_n   (vsync_n),
    .vblank    (vblank),
    .field     (field),
    .frame_stb (frame_stb)
  );

  always #5 m2clock = ~m2clock;

  function automatic int m_total();
    int t;
    t = (mmode == 2) ? 501 : (mmode == 1) ? 263 : 313;
    if (mmode != 2 && mil != 0 && mfld != 0) t = t - 1;
    return t;
  endfunction

  function automatic int m_vbe();
    return (mmode == 2) ? 34 : (mmode == 1) ? 16 : 25;
  endfunction

  task automatic m_reset();
    mv = 0; mmode = 0; mil = 0; mfld = 0; mstb = 0;
  endtask

  task automatic m_step();
    int t;
    mstb = 0;
    if (vertclk == 1'b0) begin
      t = m_total();
      if (mv >= t - 1) begin
        mv    = 0;
        mstb  = 1;
        mmode = mde1 ? 2 : (ntsc ? 1 : 0);
        mil   = (!mde1 && interlace) ? 1 : 0;
        mfld  = (mil != 0) ? ((mfld != 0) ? 0 : 1) : 0;
      end else begin
        mv = mv + 1;
      end
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int t;
    t = m_total();
    chk("vcnt", vcnt, mv);
    chk("vsync_n", vsync_n, (mv >= t - 3) ? 0 : 1);
    chk("vblank", vblank,
        (mv < m_vbe() || mv >= t - 5) ? 1 : 0);
    chk("field", field, mfld);
    chk("frame_stb", frame_stb, mstb);
  endtask

  task automatic tick();
    @(posedge m2clock);
    m_step();
    #1;
    check_all();
  endtask

  task automatic pulse();
    vertclk = 1'b0;
    tick();
    vertclk = 1'b1;
    tick();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (mv != target && n < 600) begin
      pulse();
      n++;
    end
    chk("reach", vcnt, target);
  endtask

  initial begin
    resb      = 1'b0;
    vertclk   = 1'b1;
    mde1      = 1'b0;
    ntsc      = 1'b0;
    interlace = 1'b0;
    m_reset();
    #12;
    chk("rst_vcnt", vcnt, 0);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_field", field, 0);
    chk("rst_stb", frame_stb, 0);
    @(posedge m2clock);
    #1;
    resb = 1'b1;

    // PAL blank end
    repeat (24) pulse();
    chk("pal_v24", vcnt, 24);
    chk("pal_vb24", vblank, 1);
    pulse();
    chk("pal_vb25", vblank, 0);

    // PAL vsync, mid-frame ntsc request
    run_to(100);
    ntsc = 1'b1;
    run_to(308);
    chk("pal_vb308", vblank, 1);
    chk("pal_vs308", vsync_n, 1);
    run_to(310);
    chk("pal_vs310", vsync_n, 0);
    run_to(312);
    chk("pal_vs312", vsync_n, 0);
    vertclk = 1'b0;
    tick();
    chk("pal_wrap", vcnt, 0);
    chk("pal_stb", frame_stb, 1);
    chk("pal_vs0", vsync_n, 1);
    vertclk = 1'b1;
    tick();
    chk("pal_stb_off", frame_stb, 0);

    // NTSC frame
    run_to(15);
    chk("ntsc_vb15", vblank, 1);
    pulse();
    chk("ntsc_vb16", vblank, 0);
    run_to(259);
    chk("ntsc_vs259", vsync_n, 1);
    pulse();
    chk("ntsc_vs260", vsync_n, 0);
    ntsc      = 1'b0;
    interlace = 1'b1;
    run_to(262);
    pulse();
    chk("ntsc_wrap", vcnt, 0);
    chk("il_field1", field, 1);

    // PAL interlace short field
    run_to(306);
    chk("il_vb306", vblank, 0);
    pulse();
    chk("il_vb307", vblank, 1);
    run_to(308);
    chk("il_vs308", vsync_n, 1);
    pulse();
    chk("il_vs309", vsync_n, 0);
    run_to(311);
    pulse();
    chk("il_wrap", vcnt, 0);
    chk("il_field0", field, 0);
    mde1 = 1'b1;
    run_to(312);
    pulse();
    chk("il_long_wrap", vcnt, 0);

    // mono, two frames
    for (int f = 0; f < 2; f++) begin
      chk("mono_field", field, 0);
      run_to(33);
      chk("mono_vb33", vblank, 1);
      pulse();
      chk("mono_vb34", vblank, 0);
      run_to(495);
      chk("mono_vb495", vblank, 0);
      pulse();
      chk("mono_vb496", vblank, 1);
      run_to(497);
      chk("mono_vs497", vsync_n, 1);
      pulse();
      chk("mono_vs498", vsync_n, 0);
      if (f == 1) begin
        mde1      = 1'b0;
        interlace = 1'b0;
      end
      run_to(500);
      pulse();
      chk("mono_wrap", vcnt, 0);
    end

    // held low advances one line per cycle
    run_to(50);
    vertclk = 1'b0;
    repeat (3) tick();
    vertclk = 1'b1;
    tick();
    chk("hold3", vcnt, 53);

    // async reset in vsync
    ntsc = 1'b1;
    run_to(311);
    chk("pre_rst_vs", vsync_n, 0);
    resb = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("arst_vs", vsync_n, 1);
    chk("arst_vb", vblank, 1);
    @(posedge m2clock);
    #1;
    resb = 1'b1;
    ntsc = 1'b0;
    run_to(310);
    chk("post_rst_pal", vsync_n, 0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mde1      = ($urandom_range(0, 3) == 0);
        ntsc      = $urandom_range(0, 1) == 1;
        interlace = $urandom_range(0, 1) == 1;
      end
      vertclk = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
      vertclk = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
